// File: rtl/uart_rx_sipo_if.sv
// Receive-side UART bundle: serial line in, received byte and frame status out.
interface uart_rx_sipo_if;
    logic       data_rx;
    logic [7:0] data_out;
    logic       parity_error;
    logic       frame_error;
    logic       done_flag;
    logic       active_flag;

    modport master (
        input  data_rx,
        output data_out, parity_error, frame_error, done_flag, active_flag
    );

    modport slave (
        output data_rx,
        input  data_out, parity_error, frame_error, done_flag, active_flag
    );
endinterface

// File: rtl/uart_rx_sipo.sv
// UART receiver: oversampled start/8 data (LSB first)/parity/stop deserialiser
// with held byte and error flags plus a one-cycle completion pulse.
module uart_rx_sipo #(
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic           baud_clk,
    input  logic           reset,
    uart_rx_sipo_if.master bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_next;
    logic          rx_meta, rx_s, rx_prev;
    logic [TW-1:0] tick_cnt, tick_next;
    logic [2:0]    bit_cnt, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          par_bit, par_next;
    logic          frame_end;
    logic [7:0]    data_q;
    logic          parity_err_q, frame_err_q, done_q;

    function automatic logic expected_parity(input logic [7:0] d);
        return (^d) ^ PARITY_ODD;
    endfunction

    // Synchroniser and edge-detect flops idle high to match the idle line.
    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.data_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            par_bit      <= 1'b0;
            data_q       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            par_bit   <= par_next;
            done_q    <= frame_end;
            if (frame_end) begin
                data_q       <= shift_reg;
                parity_err_q <= (par_bit != expected_parity(shift_reg));
                frame_err_q  <= ~rx_s;
            end
        end
    end

    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        par_next   = par_bit;
        frame_end  = 1'b0;
        case (state)
            // Only a true falling edge starts a frame, so a held-low line stays idle.
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_next = START;
                    tick_next  = '0;
                end
            end
            START: begin
                if (tick_cnt == TICK_MID) begin
                    tick_next  = '0;
                    bit_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end else begin
                    tick_next = tick_cnt + 1'b1;
                end
            end
            DATA: begin
                if (tick_cnt == TICK_END) begin
                    shift_next = {rx_s, shift_reg[7:1]};
                    tick_next  = '0;
                    bit_next   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_next = PARITY;
                end else begin
                    tick_next = tick_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (tick_cnt == TICK_END) begin
                    par_next   = rx_s;
                    tick_next  = '0;
                    state_next = STOP;
                end else begin
                    tick_next = tick_cnt + 1'b1;
                end
            end
            STOP: begin
                if (tick_cnt == TICK_END) begin
                    frame_end  = 1'b1;
                    tick_next  = '0;
                    state_next = IDLE;
                end else begin
                    tick_next = tick_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.data_out     = data_q;
    assign bus.parity_error = parity_err_q;
    assign bus.frame_error  = frame_err_q;
    assign bus.done_flag    = done_q;
    assign bus.active_flag  = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo: clean, parity-fault, framing-fault, glitch,
// back-to-back and reset-abort frames at 16x oversampling.
module tb_uart_rx_sipo;
    logic clk = 1'b0;
    logic rst;
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   fall_cyc = 0;
    int   d0;

    uart_rx_sipo_if bus();

    uart_rx_sipo #(.OVERSAMPLE(16), .PARITY_ODD(1'b0)) dut (
        .baud_clk (clk),
        .reset    (rst),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.done_flag === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 11-bit frame, 16 cycles per bit, optionally checking active mid-bit.
    task automatic send(input logic [7:0] d, input logic par, input logic stp, input bit chk_act);
        logic [10:0] frame;
        frame    = {stp, par, d, 1'b0};
        fall_cyc = cyc;
        for (int i = 0; i < 11; i++) begin
            bus.data_rx = frame[i];
            tick(8);
            if (chk_act) check($sformatf("active_bit%0d", i), bus.active_flag, 1);
            tick(8);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.data_rx = 1'b1;
        tick(3);
        check("rst_data",   bus.data_out,     8'h00);
        check("rst_perr",   bus.parity_error, 0);
        check("rst_ferr",   bus.frame_error,  0);
        check("rst_done",   bus.done_flag,    0);
        check("rst_active", bus.active_flag,  0);
        rst = 1'b0;
        tick(5);

        // Clean frame 0xA5
        d0 = done_cnt;
        send(8'hA5, 1'b0, 1'b1, 1'b1);
        check("t1_latency", done_cyc - fall_cyc, 171);
        check("t1_pulses",  done_cnt - d0, 1);
        check("t1_data",    bus.data_out, 8'hA5);
        check("t1_perr",    bus.parity_error, 0);
        check("t1_ferr",    bus.frame_error, 0);
        check("t1_idle",    bus.active_flag, 0);
        tick(10);

        // Parity fault
        d0 = done_cnt;
        send(8'hA5, 1'b1, 1'b1, 1'b0);
        check("t2_pulses", done_cnt - d0, 1);
        check("t2_data",   bus.data_out, 8'hA5);
        check("t2_perr",   bus.parity_error, 1);
        check("t2_ferr",   bus.frame_error, 0);
        tick(10);

        // Framing fault, line held low afterwards
        d0 = done_cnt;
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        bus.data_rx = 1'b0;
        tick(40);
        check("t3_data",     bus.data_out, 8'h3C);
        check("t3_ferr",     bus.frame_error, 1);
        check("t3_perr",     bus.parity_error, 0);
        check("t3_low_idle", bus.active_flag, 0);
        check("t3_pulses",   done_cnt - d0, 1);
        bus.data_rx = 1'b1;
        tick(20);
        check("t3_no_second", done_cnt - d0, 1);
        check("t3_idle",      bus.active_flag, 0);

        // Glitch of 4 cycles
        d0 = done_cnt;
        bus.data_rx = 1'b0;
        tick(4);
        bus.data_rx = 1'b1;
        tick(1);
        check("t4_active_pulse", bus.active_flag, 1);
        tick(20);
        check("t4_back_idle", bus.active_flag, 0);
        check("t4_no_done",   done_cnt - d0, 0);
        check("t4_data_held", bus.data_out, 8'h3C);
        check("t4_ferr_held", bus.frame_error, 1);
        check("t4_perr_held", bus.parity_error, 0);

        // Back-to-back 0x00 then 0xFF
        d0 = done_cnt;
        send(8'h00, 1'b0, 1'b1, 1'b0);
        check("t5_data0", bus.data_out, 8'h00);
        check("t5_ferr0", bus.frame_error, 0);
        check("t5_perr0", bus.parity_error, 0);
        send(8'hFF, 1'b0, 1'b1, 1'b0);
        check("t5_data1",  bus.data_out, 8'hFF);
        check("t5_ferr1",  bus.frame_error, 0);
        check("t5_perr1",  bus.parity_error, 0);
        check("t5_pulses", done_cnt - d0, 2);
        tick(10);

        // Reset during data bit 4 of 0x5A
        d0 = done_cnt;
        bus.data_rx = 1'b0;
        tick(16);
        bus.data_rx = 1'b0; tick(16);
        bus.data_rx = 1'b1; tick(16);
        bus.data_rx = 1'b0; tick(16);
        bus.data_rx = 1'b1; tick(16);
        bus.data_rx = 1'b1;
        tick(8);
        check("t6_active_before", bus.active_flag, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_data",   bus.data_out, 8'h00);
        check("t6_rst_perr",   bus.parity_error, 0);
        check("t6_rst_ferr",   bus.frame_error, 0);
        check("t6_rst_done",   bus.done_flag, 0);
        check("t6_rst_active", bus.active_flag, 0);
        tick(3);
        rst = 1'b0;
        tick(20);
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_idle",    bus.active_flag, 0);
        send(8'h5A, 1'b0, 1'b1, 1'b1);
        check("t6_data",   bus.data_out, 8'h5A);
        check("t6_perr",   bus.parity_error, 0);
        check("t6_ferr",   bus.frame_error, 0);
        check("t6_pulses", done_cnt - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
UART receive stage that consumes the serial frame produced by the transmit-side PISO: start (0), 8 data bits LSB first, parity bit, stop (1). It oversamples the line, validates the start bit, shifts in data, checks parity and stop, and presents the byte with status flags. It sits between the RX pin and the receive-side buffer or consumer logic.

Parameters:
OVERSAMPLE, 16, baud_clk cycles per bit period. Must be even and at least 4.
PARITY_ODD, 0, 0 = even parity (parity bit = XOR of data); 1 = odd parity (parity bit = ~XOR of data).

Ports:
baud_clk  input  1  Oversampled clock from BaudGen, at OVERSAMPLE x bit rate.
reset  input  1  Asynchronous, active-high reset.
data_rx  input  1  Serial line, asynchronous to baud_clk; idles high.
data_out  output  8  Last received byte; held until the next completed frame.
parity_error  output  1  Parity mismatch on the last completed frame; held.
frame_error  output  1  Stop bit sampled low on the last completed frame; held.
done_flag  output  1  One-cycle pulse when a frame completes.
active_flag  output  1  High while a frame is being received (state != IDLE).

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE; all counters = 0; shift register = 0.
  - data_out = 0x00; parity_error = 0; frame_error = 0; done_flag = 0; active_flag = 0.
  - Both synchroniser flops and the edge-detect flop = 1.
- Input path: 2-flop synchroniser produces rx_s. rx_prev is rx_s delayed one cycle. All decisions use rx_s, so there is 2 cycles of input latency.
- Counters: tick_cnt, width clog2(OVERSAMPLE), counts baud_clk cycles within a bit. bit_cnt, 3 bits, indexes data bits.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On a falling edge (rx_prev=1, rx_s=0): go to START, tick_cnt = 0.
  - A level low without an edge does not start a frame. After a break or framing error, the line must return high first.
- START:
  - tick_cnt increments each cycle.
  - At tick_cnt == OVERSAMPLE/2-1 (mid start bit), sample rx_s:
    - 0: go to DATA, tick_cnt = 0, bit_cnt = 0.
    - 1: false start (glitch); go to IDLE with no flags changed.
- DATA:
  - At tick_cnt == OVERSAMPLE-1: shift right, inserting rx_s at bit 7. Set tick_cnt = 0 and increment bit_cnt.
  - After the sample with bit_cnt == 7: go to PARITY.
- PARITY: at tick_cnt == OVERSAMPLE-1, capture rx_s as the parity bit and go to STOP.
- STOP: at tick_cnt == OVERSAMPLE-1, sample the stop bit and go to IDLE. In the same edge, register:
  - data_out = shift register.
  - parity_error = (captured parity != expected parity).
  - frame_error = ~rx_s.
  - done_flag = 1 for exactly one cycle.
- Timing: the stop sample occurs OVERSAMPLE/2 + 10*OVERSAMPLE cycles (168 at default) after the IDLE->START transition. done_flag is visible in the following cycle.
- Flag hold: data_out and both error flags update only on frame completion. A false start does not update them. A frame with errors still updates data_out.
- Back-to-back frames: IDLE can accept a new falling edge in the cycle after returning from STOP.
- Reset mid-frame: aborts immediately to reset values. The partial frame is discarded and done_flag is not pulsed.
- Line noise during DATA, PARITY or STOP is not filtered. Each bit uses a single sample at the bit midpoint.

Test Plan:
1. Clean frame, default parameters: send 0xA5 with parity 0 and stop 1, each bit 16 cycles. Required: one done_flag pulse ~171 cycles after the data_rx fall; data_out = 0xA5; parity_error = 0; frame_error = 0; active_flag high throughout the frame.
2. Parity fault: send 0xA5 with parity bit 1. Required: data_out = 0xA5, parity_error = 1, frame_error = 0, one done pulse.
3. Framing fault: send 0x3C (parity 0) with stop bit 0, holding the line low for a further 40 cycles, then high. Required: frame_error = 1; no second frame or done pulse until the line rises and falls again.
4. Glitch rejection: drive data_rx low for 4 cycles, then high. Required: active_flag pulses briefly, then returns to 0; no done_flag; data_out and flags unchanged.
5. Back-to-back: 0x00 then 0xFF (parity 0 for both), with no idle gap after stop. Required: two done pulses, data_out = 0x00 then 0xFF, no errors.
6. Reset mid-frame: assert reset during data bit 4 of 0x5A. Required: all outputs are 0 immediately (asynchronous); no done pulse. A subsequent clean 0x5A frame is received correctly.
